// File: rtl/axi4_mem_slave.sv
// AXI4 memory-backed slave: independent write/read paths, one outstanding burst each,
// FIXED/INCR/WRAP bursts, full-width beats, SLVERR on illegal bursts or wlast misuse.
module axi4_mem_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wstate_t               r_wstate;
    logic                  r_awready, r_wready, r_bvalid, r_wbad_burst, r_werr;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp, r_wburst;
    logic [IDX_W-1:0]      r_widx;
    logic [7:0]            r_wlen, r_wcnt;

    rstate_t               r_rstate;
    logic                  r_arready, r_rvalid, r_rlast, r_rbad_burst;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [1:0]            r_rresp, r_rburst;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0]      r_ridx;
    logic [7:0]            r_rlen, r_rcnt;

    logic                  w_aw_hs, w_w_hs, w_w_final, w_wlast_bad, w_mem_we;
    logic                  w_ar_hs, w_r_hs, w_ar_bad;
    logic [IDX_W-1:0]      w_aw_idx, w_ar_idx;
    logic [7:0]            w_rcnt_nxt;
    logic                  w_unused;

    function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx,
                                                input logic [1:0] burst,
                                                input logic [7:0] len);
        logic [IDX_W-1:0] m;
        m = IDX_W'(len);
        case (burst)
            2'b00:   return idx;
            2'b10:   return (idx & ~m) | ((idx + IDX_W'(1)) & m);
            default: return idx + IDX_W'(1);
        endcase
    endfunction

    function automatic logic f_illegal(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                      (len == 8'd7) || (len == 8'd15)));
    endfunction

    assign w_aw_idx    = awaddr[LSB +: IDX_W];
    assign w_ar_idx    = araddr[LSB +: IDX_W];
    assign w_aw_hs     = awvalid & r_awready;
    assign w_w_hs      = wvalid & r_wready;
    assign w_w_final   = (r_wcnt == r_wlen);
    assign w_wlast_bad = (wlast != w_w_final);
    assign w_mem_we    = w_w_hs & ~r_wbad_burst;
    assign w_ar_hs     = arvalid & r_arready;
    assign w_r_hs      = r_rvalid & rready;
    assign w_ar_bad    = f_illegal(arburst, arlen);
    assign w_rcnt_nxt  = r_rcnt + 8'd1;
    assign w_unused    = ^{awaddr, araddr};

    // Storage is deliberately not reset; beats written before a reset survive it.
    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) r_mem[r_widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Write FSM: burst length is counted; wlast is only checked for consistency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate     <= W_IDLE;
            r_awready    <= 1'b1;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bid        <= '0;
            r_bresp      <= 2'b00;
            r_widx       <= '0;
            r_wlen       <= '0;
            r_wburst     <= 2'b00;
            r_wcnt       <= '0;
            r_wbad_burst <= 1'b0;
            r_werr       <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_aw_hs) begin
                    r_widx       <= w_aw_idx;
                    r_wlen       <= awlen;
                    r_wburst     <= awburst;
                    r_wcnt       <= '0;
                    r_wbad_burst <= f_illegal(awburst, awlen);
                    r_werr       <= 1'b0;
                    r_bid        <= awid;
                    r_awready    <= 1'b0;
                    r_wready     <= 1'b1;
                    r_wstate     <= W_DATA;
                end
                W_DATA: if (w_w_hs) begin
                    r_widx <= f_next(r_widx, r_wburst, r_wlen);
                    r_wcnt <= r_wcnt + 8'd1;
                    if (w_wlast_bad) r_werr <= 1'b1;
                    if (w_w_final) begin
                        r_wready <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= (r_wbad_burst | r_werr | w_wlast_bad) ? 2'b10 : 2'b00;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: if (r_bvalid && bready) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wstate  <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: next beat is fetched on the same edge as the handshake (old data on collision).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate     <= R_IDLE;
            r_arready    <= 1'b1;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_rid        <= '0;
            r_rresp      <= 2'b00;
            r_rdata      <= '0;
            r_ridx       <= '0;
            r_rlen       <= '0;
            r_rburst     <= 2'b00;
            r_rcnt       <= '0;
            r_rbad_burst <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_rdata      <= w_ar_bad ? '0 : r_mem[w_ar_idx];
                    r_ridx       <= f_next(w_ar_idx, arburst, arlen);
                    r_rlen       <= arlen;
                    r_rburst     <= arburst;
                    r_rcnt       <= '0;
                    r_rbad_burst <= w_ar_bad;
                    r_rid        <= arid;
                    r_rresp      <= w_ar_bad ? 2'b10 : 2'b00;
                    r_rlast      <= (arlen == 8'd0);
                    r_rvalid     <= 1'b1;
                    r_arready    <= 1'b0;
                    r_rstate     <= R_DATA;
                end
                R_DATA: if (w_r_hs) begin
                    if (r_rcnt == r_rlen) begin
                        r_rvalid  <= 1'b0;
                        r_rlast   <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end else begin
                        r_rdata <= r_rbad_burst ? '0 : r_mem[r_ridx];
                        r_ridx  <= f_next(r_ridx, r_rburst, r_rlen);
                        r_rcnt  <= w_rcnt_nxt;
                        r_rlast <= (w_rcnt_nxt == r_rlen);
                    end
                end
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Scoreboard bench for axi4_mem_slave: drivers push expected B/R responses from a
// word-level memory model; a negedge monitor pops and compares on every handshake.
module tb_axi4_mem_slave;
    localparam int unsigned DW = 32, AW = 32, IW = 4, DEPTH = 1024, SW = DW / 8;

    logic          aclk = 1'b0, aresetn = 1'b0;
    logic [IW-1:0] awid = '0, arid = '0, bid, rid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0]    awlen = '0, arlen = '0;
    logic [1:0]    awburst = '0, arburst = '0, bresp, rresp;
    logic          awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
    logic          arvalid = 0, arready, rlast, rvalid, rready = 0;
    logic [DW-1:0] wdata = '0, rdata;
    logic [SW-1:0] wstrb = '0;

    always #5 aclk = ~aclk;

    axi4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready));

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t        bq[$];
    r_exp_t        rq[$];
    b_exp_t        eb;
    r_exp_t        er;
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] wd [256];
    logic [SW-1:0] ws [256];
    int            n_cmp = 0, n_err = 0;
    logic          hold_v = 1'b0, hold_l;
    logic [DW-1:0] hold_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Word visited on beat k of a burst, from the address-sequence rules.
    function automatic int unsigned beat_idx(input int unsigned idx0, input int unsigned len,
                                             input int unsigned burst, input int unsigned k);
        int unsigned span, base;
        if (burst == 0) return idx0;
        if (burst == 2) begin
            span = len + 1;
            base = (idx0 / span) * span;
            return base + (idx0 - base + k) % span;
        end
        return (idx0 + k) % DEPTH;
    endfunction

    function automatic bit bad_burst(input int unsigned burst, input int unsigned len);
        return (burst == 3) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic int unsigned word_of(input logic [AW-1:0] addr);
        return (int'(addr) / SW) % DEPTH;
    endfunction

    always @(negedge aclk) begin
        if (aresetn) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) timeout("b_unexpected");
                else begin
                    eb = bq.pop_front();
                    check("bid", 64'(bid), 64'(eb.id));
                    check("bresp", 64'(bresp), 64'(eb.resp));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) timeout("r_unexpected");
                else begin
                    er = rq.pop_front();
                    check("rid", 64'(rid), 64'(er.id));
                    check("rdata", 64'(rdata), 64'(er.data));
                    check("rresp", 64'(rresp), 64'(er.resp));
                    check("rlast", 64'(rlast), 64'(er.last));
                end
            end
            if (hold_v && rvalid) begin
                check("r_stall_data", 64'(rdata), 64'(hold_d));
                check("r_stall_last", 64'(rlast), 64'(hold_l));
            end
            hold_v = rvalid && !rready;
            hold_d = rdata;
            hold_l = rlast;
        end else hold_v = 1'b0;
    end

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [1:0] burst, input int bad_last);
        int unsigned idx0, idx;
        int n, k;
        bit bad, done;
        bad  = bad_burst(burst, len);
        idx0 = word_of(addr);
        bq.push_back('{id, (bad || bad_last >= 0) ? 2'b10 : 2'b00});
        if (!bad)
            for (int j = 0; j <= len; j++) begin
                idx = beat_idx(idx0, len, burst, j);
                for (int b = 0; b < SW; b++)
                    if (ws[j][b]) mdl[idx][b*8 +: 8] = wd[j][b*8 +: 8];
            end
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 50);
        if (!awready) begin timeout("aw_handshake"); awvalid = 1'b0; return; end
        @(posedge aclk); #1 awvalid = 1'b0;
        check("wready_after_aw", 64'(wready), 64'd1);
        k = 0; n = 0;
        while (k <= len && n < 2000) begin
            wvalid = ($urandom % 4 != 0);
            wdata  = wd[k];
            wstrb  = ws[k];
            wlast  = (k == len) ^ (k == bad_last);
            @(negedge aclk); n++;
            if (wvalid && wready) k++;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (k <= len) begin timeout("w_beats"); return; end
        check("bvalid_after_last_w", 64'(bvalid), 64'd1);
        check("wready_after_last_w", 64'(wready), 64'd0);
        n = 0; done = 0;
        while (!done && n < 200) begin
            bready = ($urandom % 2 == 0);
            @(negedge aclk); n++;
            if (bvalid && bready) done = 1;
            @(posedge aclk); #1;
        end
        bready = 1'b0;
        if (!done) begin timeout("b_handshake"); return; end
        check("awready_after_b", 64'(awready), 64'd1);
        check("bvalid_after_b", 64'(bvalid), 64'd0);
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] burst, input bit toggle);
        int unsigned idx0;
        int n, hs, vcyc;
        bit bad, phase;
        bad  = bad_burst(burst, len);
        idx0 = word_of(addr);
        for (int j = 0; j <= len; j++)
            rq.push_back('{id, bad ? '0 : mdl[beat_idx(idx0, len, burst, j)], bad ? 2'b10 : 2'b00, j == len});
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 50);
        if (!arready) begin timeout("ar_handshake"); arvalid = 1'b0; return; end
        @(posedge aclk); #1 arvalid = 1'b0;
        check("rvalid_after_ar", 64'(rvalid), 64'd1);
        hs = 0; n = 0; vcyc = 0; phase = 1'b1;
        while (hs <= len && n < 4000) begin
            rready = toggle ? phase : ($urandom % 4 != 0);
            phase  = !phase;
            @(negedge aclk); n++;
            if (rvalid) vcyc++;
            if (rvalid && rready) hs++;
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        if (hs <= len) begin timeout("r_beats"); return; end
        if (toggle) check("r_toggle_cycles", 64'(vcyc), 64'(2 * len + 1));
        check("arready_after_last_r", 64'(arready), 64'd1);
        check("rvalid_after_last_r", 64'(rvalid), 64'd0);
        check("rlast_after_last_r", 64'(rlast), 64'd0);
    endtask

    initial begin
        int unsigned base, len, burst;
        #12;
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
        check("rst_rid_rresp", 64'({rid, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        @(posedge aclk); #1 aresetn = 1'b1;

        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 256; k++) begin wd[k] = $urandom; ws[k] = '1; end
            do_write(IW'(f), AW'(f * 1024), 255, 2'b01, -1);
        end

        for (int k = 0; k < 4; k++) begin wd[k] = DW'(32'hA0 + k); ws[k] = '1; end
        do_write(4'h5, 32'h100, 3, 2'b01, -1);
        do_read(4'h5, 32'h100, 3, 2'b01, 0);

        for (int k = 0; k < 4; k++) wd[k] = DW'(k + 1);
        do_write(4'h2, 32'h10, 3, 2'b01, -1);
        do_read(4'h3, 32'h18, 3, 2'b10, 0);

        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'h1, 32'h200, 0, 2'b01, -1);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'h3;
        do_write(4'h1, 32'h200, 0, 2'b01, -1);
        do_read(4'h1, 32'h200, 0, 2'b01, 0);

        wd[0] = 32'hCAFE0000; wd[1] = 32'hCAFE0001; ws[0] = '1; ws[1] = '1;
        do_write(4'h4, 32'h200, 1, 2'b11, -1);
        do_read(4'h4, 32'h200, 1, 2'b01, 0);
        do_write(4'h6, 32'h220, 1, 2'b01, 0);
        do_read(4'h6, 32'h220, 1, 2'b01, 0);
        do_read(4'h7, 32'h40, 2, 2'b10, 0);
        do_read(4'h7, 32'h40, 1, 2'b11, 0);

        do_read(4'h8, 32'h100, 7, 2'b01, 1);

        // Reset in the middle of beat 2 of an 8-beat write.
        for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = '1; end
        awid = 4'h9; awaddr = 32'h300; awlen = 8'd7; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = wd[k]; wstrb = '1; wlast = 1'b0;
            mdl[word_of(32'h300) + k] = wd[k];
            @(posedge aclk); #1;
        end
        wdata = wd[2];
        #2 aresetn = 1'b0;
        #1;
        check("rst_mid_awready", 64'(awready), 64'd1);
        check("rst_mid_wready", 64'(wready), 64'd0);
        check("rst_mid_bvalid", 64'(bvalid), 64'd0);
        wvalid = 1'b0;
        @(posedge aclk); #3 aresetn = 1'b1;
        @(posedge aclk); #1;
        do_read(4'h9, 32'h300, 7, 2'b01, 0);

        for (int t = 0; t < 40; t++) begin
            burst = $urandom % 4;
            len   = (burst == 2 && $urandom % 4 != 0) ? (2 << ($urandom % 4)) - 1 : $urandom % 16;
            base  = $urandom;
            if (t % 2 == 0) begin
                for (int k = 0; k <= int'(len); k++) begin wd[k] = $urandom; ws[k] = SW'($urandom); end
                do_write(IW'($urandom), AW'(base), int'(len), 2'(burst), ($urandom % 8 == 0) ? 0 : -1);
            end else
                do_read(IW'($urandom), AW'(base), int'(len), 2'(burst), 0);
        end

        repeat (4) @(posedge aclk);
        check("b_queue_drained", 64'(bq.size()), 64'd0);
        check("r_queue_drained", 64'(rq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
